// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional performance counters in fetch_unit are enabled with FETCH_PERF_EN.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] PC_STEP        = 32'd4;
   localparam logic [31:0] PC_ALIGN_MASK  = 32'hFFFF_FFFC;
   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH entries of {pc, instr}; flush overrides push and pop.
// Head outputs read zero while the buffer is empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t wr_i,
   output fetch_entry_t head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // NOTE: storage has no reset; the count alone decides validity and empty_o masks stale data.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wr_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
         else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, BOOT/RUN/HALT control and fetch buffer towards decode.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_flush_cnt counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         push, pop, fifo_full, fifo_empty;
   fetch_entry_t head;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .wr_i    ('{pc: pc_q, instr: imem_instr}),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign imem_pc     = pc_q;
   assign id_valid    = !fifo_empty;
   assign id_instr    = head.instr;
   assign id_pc       = head.pc;
   assign id_pc_plus4 = head.pc + PC_STEP;
   assign pop         = id_valid && id_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // NOTE: combinational next-state logic uses blocking '=' with every output defaulted first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      if (redirect_valid) begin
         state_d = RUN;
         pc_d    = redirect_pc & PC_ALIGN_MASK;
      end else begin
         case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
               push = !fifo_full || pop;
               if (push)     pc_d    = pc_q + PC_STEP;
               if (halt_req) state_d = HALT;
            end
            HALT:    state_d = HALT;
            default: state_d = BOOT;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetch_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (push)           perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] imem_pc, imem_instr;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt_req = 1'b0;
   logic        id_valid, id_ready = 1'b0;
   logic [31:0] id_instr, id_pc, id_pc_plus4;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] tmem [64];
   assign imem_instr = tmem[imem_pc[7:2]];

   fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_pc        (imem_pc),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return tmem[pc[7:2]];
   endfunction

   // Reference model: ordered queue of fetched words plus PC and mode flags.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc;
   bit          m_boot, m_halt;
   int unsigned m_pushes, m_flushes;

   task automatic model_reset();
      m_q.delete();
      m_pc      = 32'h0;
      m_boot    = 1'b1;
      m_halt    = 1'b0;
      m_pushes  = 0;
      m_flushes = 0;
   endtask

   task automatic model_check();
      check("imem_pc", imem_pc, m_pc);
      check("id_valid", {31'b0, id_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) begin
         check("id_pc", id_pc, m_q[0].pc);
         check("id_instr", id_instr, m_q[0].instr);
         check("id_pc_plus4", id_pc_plus4, m_q[0].pc + 32'd4);
      end
`ifdef FETCH_PERF_EN
      check("perf_fetch_cnt", perf_fetch_cnt, m_pushes);
      check("perf_flush_cnt", perf_flush_cnt, m_flushes);
`endif
   endtask

   task automatic model_update();
      bit do_pop;
      if (redirect_valid) begin
         m_q.delete();
         m_pc   = {redirect_pc[31:2], 2'b00};
         m_boot = 1'b0;
         m_halt = 1'b0;
         m_flushes++;
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else begin
         do_pop = id_ready && (m_q.size() != 0);
         if (do_pop) void'(m_q.pop_front());
         if (!m_halt && (m_q.size() < DEPTH)) begin
            m_q.push_back('{pc: m_pc, instr: word_at(m_pc)});
            m_pc = m_pc + 32'd4;
            m_pushes++;
         end
         if (!m_halt && halt_req) m_halt = 1'b1;
      end
   endtask

   // One clock: apply inputs, check pre-edge outputs, advance model with the edge.
   task automatic step(input logic red, input logic [31:0] rpc, input logic hlt, input logic rdy);
      redirect_valid = red;
      redirect_pc    = rpc;
      halt_req       = hlt;
      id_ready       = rdy;
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   typedef struct {
      logic        red;
      logic [31:0] rpc;
      logic        hlt;
      logic        rdy;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_imem;
   } vec_t;

   vec_t vecs[23];

   function automatic vec_t mk(input logic red, input logic [31:0] rpc, input logic hlt,
                               input logic rdy, input logic ev, input logic [31:0] epc,
                               input logic [31:0] eim);
      vec_t v;
      v.red = red; v.rpc = rpc; v.hlt = hlt; v.rdy = rdy;
      v.exp_valid = ev; v.exp_pc = epc; v.exp_imem = eim;
      return v;
   endfunction

   initial begin
      for (int i = 0; i < 64; i++) tmem[i] = $urandom;
      tmem[0]  = 32'h0094_0333;
      tmem[1]  = 32'h8001_00B3;
      tmem[23] = 32'h0000_80EF;

      //              red  rpc           hlt  rdy  valid id_pc         imem_pc
      vecs[0]  = mk(0, 32'h0,        0, 1, 0, 32'h0,        32'h00);
      vecs[1]  = mk(0, 32'h0,        0, 1, 1, 32'h0,        32'h04);
      vecs[2]  = mk(0, 32'h0,        0, 1, 1, 32'h4,        32'h08);
      vecs[3]  = mk(0, 32'h0,        0, 0, 1, 32'h4,        32'h0C);
      for (int i = 4; i < 9; i++) vecs[i] = mk(0, 32'h0, 0, 0, 1, 32'h4, 32'h0C);
      vecs[9]  = mk(0, 32'h0,        0, 1, 1, 32'h8,        32'h10);
      vecs[10] = mk(0, 32'h0,        0, 1, 1, 32'hC,        32'h14);
      vecs[11] = mk(1, 32'h5E,       0, 1, 0, 32'h0,        32'h5C);
      vecs[12] = mk(0, 32'h0,        0, 0, 1, 32'h5C,       32'h60);
      vecs[13] = mk(1, 32'h10,       0, 1, 0, 32'h0,        32'h10);
      vecs[14] = mk(0, 32'h0,        1, 0, 1, 32'h10,       32'h14);
      vecs[15] = mk(0, 32'h0,        0, 0, 1, 32'h10,       32'h14);
      vecs[16] = mk(0, 32'h0,        0, 1, 0, 32'h0,        32'h14);
      vecs[17] = mk(0, 32'h0,        0, 1, 0, 32'h0,        32'h14);
      vecs[18] = mk(1, 32'h0,        0, 1, 0, 32'h0,        32'h00);
      vecs[19] = mk(0, 32'h0,        0, 1, 1, 32'h0,        32'h04);
      vecs[20] = mk(1, 32'hFFFFFFFF, 0, 1, 0, 32'h0,        32'hFFFFFFFC);
      vecs[21] = mk(0, 32'h0,        0, 0, 1, 32'hFFFFFFFC, 32'h00);
      vecs[22] = mk(0, 32'h0,        0, 1, 1, 32'h0,        32'h04);

      // Reset values while reset is held.
      model_reset();
      #12;
      check("rst imem_pc", imem_pc, 32'h0);
      check("rst id_valid", {31'b0, id_valid}, 32'h0);
      check("rst id_instr", id_instr, 32'h0);
      check("rst id_pc", id_pc, 32'h0);
      check("rst id_pc_plus4", id_pc_plus4, 32'h4);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Directed table: boot, stall, redirect, halt/drain, PC wrap.
      for (int i = 0; i < 23; i++) begin
         step(vecs[i].red, vecs[i].rpc, vecs[i].hlt, vecs[i].rdy);
         check($sformatf("vec%0d imem_pc", i), imem_pc, vecs[i].exp_imem);
         check($sformatf("vec%0d id_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d id_pc", i), id_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d id_instr", i), id_instr, word_at(vecs[i].exp_pc));
            check($sformatf("vec%0d id_pc_plus4", i), id_pc_plus4, vecs[i].exp_pc + 32'd4);
         end
      end

      // Async reset between edges, then redirect taken during BOOT.
      #2;
      reset = 1'b1;
      #1;
      check("async rst id_valid", {31'b0, id_valid}, 32'h0);
      check("async rst imem_pc", imem_pc, 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b1, 32'h5D, 1'b0, 1'b0);
      check("boot redirect imem_pc", imem_pc, 32'h5C);
      check("boot redirect id_valid", {31'b0, id_valid}, 32'h0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      check("boot redirect id_instr", id_instr, 32'h0000_80EF);
      check("boot redirect id_pc", id_pc, 32'h5C);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 800; i++) begin
         logic        red, hlt, rdy;
         logic [31:0] rpc;
         red = ($urandom_range(0, 9) == 0);
         hlt = ($urandom_range(0, 11) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom_range(0, 255));
         step(red, rpc, hlt, rdy);
      end
      step(1'b0, 32'h0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
